// File: rtl/seg_scan_if.sv
// Bundle between a multiplexed 7-segment bus monitor and its consumer:
// the active-low segment/anode bus in, decoded per-digit state out.
interface seg_scan_if #(
    parameter int DIGITS = 8
);
    logic [7:0]          seg_in;
    logic [DIGITS-1:0]   an_in;
    logic [4*DIGITS-1:0] digit_val;
    logic [DIGITS-1:0]   digit_ok;
    logic [DIGITS-1:0]   digit_dp;
    logic                frame_valid;
    logic                err;

    modport master (
        output seg_in, an_in,
        input  digit_val, digit_ok, digit_dp, frame_valid, err
    );

    modport slave (
        input  seg_in, an_in,
        output digit_val, digit_ok, digit_dp, frame_valid, err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the hex nibble shown on each digit of a multiplexed active-low
// 7-segment bus, committing a digit only after a stable dwell.
module seg_scan_decoder #(
    parameter int DIGITS     = 8,
    parameter int STABLE_CNT = 4
) (
    input logic     clk,
    input logic     rst,
    seg_scan_if.slave bus
);
    localparam logic [7:0] SAT = 8'(STABLE_CNT);

    logic [7:0]          seg_q, seg_p;
    logic [DIGITS-1:0]   an_q, an_p;
    logic [7:0]          cnt, cnt_next;
    logic [DIGITS-1:0]   sel, commit_vec, mask;
    logic                is_idle, is_multi, is_single, same;
    logic                commit, legal, blank;
    logic [3:0]          nibble;
    logic [4*DIGITS-1:0] val_r;
    logic [DIGITS-1:0]   ok_r, dp_r;
    logic                fv_r, err_r;

    // Segment bits 6:0 are active-low g..a; returns {legal, nibble}.
    function automatic logic [4:0] glyph_decode(input logic [6:0] s);
        case (s)
            7'h40:   glyph_decode = {1'b1, 4'h0};
            7'h79:   glyph_decode = {1'b1, 4'h1};
            7'h24:   glyph_decode = {1'b1, 4'h2};
            7'h30:   glyph_decode = {1'b1, 4'h3};
            7'h19:   glyph_decode = {1'b1, 4'h4};
            7'h12:   glyph_decode = {1'b1, 4'h5};
            7'h02:   glyph_decode = {1'b1, 4'h6};
            7'h78:   glyph_decode = {1'b1, 4'h7};
            7'h00:   glyph_decode = {1'b1, 4'h8};
            7'h10:   glyph_decode = {1'b1, 4'h9};
            7'h08:   glyph_decode = {1'b1, 4'hA};
            7'h03:   glyph_decode = {1'b1, 4'hB};
            7'h46:   glyph_decode = {1'b1, 4'hC};
            7'h21:   glyph_decode = {1'b1, 4'hD};
            7'h06:   glyph_decode = {1'b1, 4'hE};
            7'h0E:   glyph_decode = {1'b1, 4'hF};
            default: glyph_decode = {1'b0, 4'h0};
        endcase
    endfunction

    always_comb begin
        sel       = ~an_q;
        is_idle   = (sel == '0);
        is_multi  = ((sel & (sel - DIGITS'(1))) != '0);
        is_single = !is_idle && !is_multi;
        same      = (seg_q == seg_p) && (an_q == an_p);
        {legal, nibble} = glyph_decode(seg_q[6:0]);
        blank     = (seg_q[6:0] == 7'h7F);

        if (!is_single)
            cnt_next = '0;
        else if (same)
            cnt_next = (cnt == SAT) ? cnt : cnt + 8'd1;
        else
            cnt_next = 8'd1;

        // Commit only on the step into saturation, never while holding there.
        commit     = is_single && (cnt_next == SAT) && (cnt != SAT);
        commit_vec = commit ? sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '1;
            an_q  <= '1;
            seg_p <= '1;
            an_p  <= '1;
            cnt   <= '0;
        end else begin
            seg_q <= bus.seg_in;
            an_q  <= bus.an_in;
            seg_p <= seg_q;
            an_p  <= an_q;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_r <= '0;
            ok_r  <= '0;
            dp_r  <= '0;
            mask  <= '0;
            fv_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                if (commit_vec[k]) begin
                    dp_r[k] <= ~seg_q[7];
                    ok_r[k] <= legal;
                    if (legal)
                        val_r[4*k +: 4] <= nibble;
                end
            end

            err_r <= is_multi || (commit && !legal && !blank);

            // A full mask is reported one edge later; a commit landing on
            // that clearing edge survives into the next frame.
            fv_r <= (mask == '1);
            if (mask == '1)
                mask <= commit_vec;
            else
                mask <= mask | commit_vec;
        end
    end

    assign bus.digit_val   = val_r;
    assign bus.digit_ok    = ok_r;
    assign bus.digit_dp    = dp_r;
    assign bus.frame_valid = fv_r;
    assign bus.err         = err_r;
endmodule
